multi_channel_word_store: RTL and testbench

MULTI_CHANNEL_WORD_STORE -- requirements
Module: multi_channel_word_store

---
 rtl/multi_channel_word_store.sv | 154 +++++++++++++++
 tb/tb_multi_channel_word_store.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_word_store.sv
// rtl/multi_channel_word_store.sv - serial word capture into a per-channel bank with registered display readout
// Frames are shifted in, committed to bank[queue0], and any channel can be shown on the display port.

module multi_channel_word_store #(
  parameter int WORD_W    = 12,
  parameter int NUM_CH    = 8,
  parameter int CH_W      = 3,
  parameter int MSB_FIRST = 0
) (
  input  logic              ten_MHz_synch_in,
  input  logic              reset_in,
  input  logic              data_ctrl_in,
  input  logic              serial_in,
  input  logic [CH_W-1:0]   queue0,
  input  logic              safe_switch,
  input  logic [CH_W-1:0]   display_sel,
  input  logic              displaying_trigger_in,
  output logic [WORD_W-1:0] Hex_display_no,
  output logic              display_valid,
  output logic [NUM_CH-1:0] ch_valid,
  output logic              word_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, WAIT_END} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [WORD_W-1:0] sh_q, sh_d, sh_next;
  logic [WORD_W-1:0] bank_q [NUM_CH];
  logic [WORD_W-1:0] bank_d [NUM_CH];
  logic [NUM_CH-1:0] vld_q, vld_d;
  logic              wd_q, wd_d;
  logic              fe_q, fe_d;
  logic [WORD_W-1:0] disp_q, disp_d;
  logic              dvld_q, dvld_d;
  logic              ch_ok, sel_ok;

  assign ch_ok  = int'(ch_q) < NUM_CH;
  assign sel_ok = int'(display_sel) < NUM_CH;

  // After WORD_W shifts the first serial bit lands at bit 0 (LSB-first) or bit WORD_W-1.
  always_comb begin
    sh_next = '0;
    if (MSB_FIRST != 0) sh_next = {sh_q[WORD_W-2:0], serial_in};
    else                sh_next = {serial_in, sh_q[WORD_W-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    sh_d    = sh_q;
    bank_d  = bank_q;
    vld_d   = vld_q;
    wd_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_ctrl_in) begin
          if (safe_switch) begin
            state_d = WAIT_END;
          end else begin
            state_d = SHIFT;
            sh_d    = sh_next;
            ch_d    = queue0;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      SHIFT: begin
        if (safe_switch) begin
          fe_d    = 1'b1;
          state_d = data_ctrl_in ? WAIT_END : IDLE;
        end else if (data_ctrl_in) begin
          sh_d  = sh_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WORD_W - 1)) state_d = COMMIT;
        end else begin
          fe_d    = 1'b1;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        state_d = data_ctrl_in ? WAIT_END : IDLE;
        // A lock raised during the commit cycle still blocks the write.
        if (ch_ok && !safe_switch) begin
          bank_d[ch_q] = sh_q;
          vld_d[ch_q]  = 1'b1;
          wd_d         = 1'b1;
        end else begin
          fe_d = 1'b1;
        end
      end
      WAIT_END: begin
        if (!data_ctrl_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display reads the pre-write bank, so a same-edge write shows up one load later.
  always_comb begin
    disp_d = disp_q;
    dvld_d = dvld_q;
    if (!displaying_trigger_in) begin
      if (sel_ok) begin
        disp_d = bank_q[display_sel];
        dvld_d = vld_q[display_sel];
      end else begin
        disp_d = '0;
        dvld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge ten_MHz_synch_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      sh_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) bank_q[i] <= '0;
      vld_q   <= '0;
      wd_q    <= 1'b0;
      fe_q    <= 1'b0;
      disp_q  <= '0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      sh_q    <= sh_d;
      bank_q  <= bank_d;
      vld_q   <= vld_d;
      wd_q    <= wd_d;
      fe_q    <= fe_d;
      disp_q  <= disp_d;
      dvld_q  <= dvld_d;
    end
  end

  assign Hex_display_no = disp_q;
  assign display_valid  = dvld_q;
  assign ch_valid       = vld_q;
  assign word_done      = wd_q;
  assign frame_err      = fe_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_multi_channel_word_store.sv
// tb/tb_multi_channel_word_store.sv - directed bench for multi_channel_word_store
// Drives on the falling edge, checks on the falling edge; a second instance uses MSB_FIRST=1.

module tb_multi_channel_word_store;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dc = 1'b0;
  logic        sin = 1'b0;
  logic        ss = 1'b0;
  logic        trig = 1'b1;
  logic [2:0]  q0 = 3'd0;
  logic [2:0]  dsel = 3'd0;

  logic [11:0] hex_a, hex_b;
  logic        dv_a, dv_b, wd_a, wd_b, fe_a, fe_b, busy_a, busy_b;
  logic [7:0]  chv_a, chv_b;

  int errors = 0;
  int checks = 0;
  int wd_cnt = 0;
  int fe_cnt = 0;
  int wd0, fe0;

  multi_channel_word_store #(.WORD_W(12), .NUM_CH(8), .CH_W(3), .MSB_FIRST(0)) dut_a (
    .ten_MHz_synch_in(clk), .reset_in(rst), .data_ctrl_in(dc), .serial_in(sin),
    .queue0(q0), .safe_switch(ss), .display_sel(dsel), .displaying_trigger_in(trig),
    .Hex_display_no(hex_a), .display_valid(dv_a), .ch_valid(chv_a),
    .word_done(wd_a), .frame_err(fe_a), .busy(busy_a)
  );

  multi_channel_word_store #(.WORD_W(12), .NUM_CH(8), .CH_W(3), .MSB_FIRST(1)) dut_b (
    .ten_MHz_synch_in(clk), .reset_in(rst), .data_ctrl_in(dc), .serial_in(sin),
    .queue0(q0), .safe_switch(ss), .display_sel(dsel), .displaying_trigger_in(trig),
    .Hex_display_no(hex_b), .display_valid(dv_b), .ch_valid(chv_b),
    .word_done(wd_b), .frame_err(fe_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wd_a) wd_cnt++;
    if (fe_a) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [2:0] ch, input logic [15:0] w,
                           input int first, input int last, input bit msb);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      dc  = 1'b1;
      q0  = ch;
      sin = msb ? w[11 - i] : w[i];
    end
  endtask

  task automatic end_frame;
    @(negedge clk);
    dc  = 1'b0;
    sin = 1'b0;
  endtask

  task automatic read_sel(input logic [2:0] ch);
    @(negedge clk);
    dsel = ch;
    trig = 1'b0;
    @(negedge clk);
    trig = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hex", hex_a, 12'h000);
    check("rst_dv", dv_a, 1'b0);
    check("rst_wd", wd_a, 1'b0);
    check("rst_fe", fe_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_chv", chv_a, 8'h00);
    rst = 1'b0;

    // full word to channel 3, with latency
    wd0 = wd_cnt;
    send_bits(3'd3, 16'h0A5C, 0, 11, 1'b0);
    @(negedge clk);
    check("lat_pre_wd", wd_a, 1'b0);
    check("commit_busy", busy_a, 1'b1);
    dc = 1'b0;
    @(negedge clk);
    check("lat_wd", wd_a, 1'b1);
    check("wr_chv", chv_a, 8'h08);
    @(negedge clk);
    check("wd_pulse_end", wd_a, 1'b0);
    check("wr_idle_busy", busy_a, 1'b0);
    read_sel(3'd3);
    check("wr_hex", hex_a, 12'hA5C);
    check("wr_dv", dv_a, 1'b1);
    check("wr_wd_count", wd_cnt - wd0, 1);

    // display holds while trigger is high
    @(negedge clk);
    dsel = 3'd1;
    @(negedge clk);
    check("hold_hex", hex_a, 12'hA5C);
    check("hold_dv", dv_a, 1'b1);

    // same-channel write and read on one edge
    dsel = 3'd5;
    trig = 1'b0;
    send_bits(3'd5, 16'h03C7, 0, 11, 1'b0);
    @(negedge clk);
    dc = 1'b0;
    @(negedge clk);
    check("coll_wd", wd_a, 1'b1);
    check("coll_old", hex_a, 12'h000);
    @(negedge clk);
    check("coll_new", hex_a, 12'h3C7);
    check("coll_dv", dv_a, 1'b1);
    trig = 1'b1;
    check("coll_chv", chv_a, 8'h28);

    // short frame
    wd0 = wd_cnt; fe0 = fe_cnt;
    send_bits(3'd1, 16'h001F, 0, 4, 1'b0);
    end_frame();
    @(negedge clk);
    check("short_fe", fe_a, 1'b1);
    check("short_busy", busy_a, 1'b0);
    repeat (3) @(negedge clk);
    check("short_fe_count", fe_cnt - fe0, 1);
    check("short_wd_count", wd_cnt - wd0, 0);
    check("short_chv", chv_a, 8'h28);
    read_sel(3'd1);
    check("short_hex", hex_a, 12'h000);
    check("short_dv", dv_a, 1'b0);

    // lock raised after bit 6
    wd0 = wd_cnt; fe0 = fe_cnt;
    send_bits(3'd2, 16'h0FFF, 0, 5, 1'b0);
    @(negedge clk);
    ss = 1'b1; dc = 1'b1; sin = 1'b1;
    @(negedge clk);
    check("lock_fe", fe_a, 1'b1);
    check("lock_busy", busy_a, 1'b1);
    ss = 1'b0;
    send_bits(3'd2, 16'h0FFF, 7, 11, 1'b0);
    end_frame();
    check("lock_busy_tail", busy_a, 1'b1);
    @(negedge clk);
    check("lock_idle", busy_a, 1'b0);
    check("lock_fe_count", fe_cnt - fe0, 1);
    check("lock_wd_count", wd_cnt - wd0, 0);
    read_sel(3'd2);
    check("lock_hex", hex_a, 12'h000);
    check("lock_dv", dv_a, 1'b0);

    // overlong frame: 15 bits, first 12 are 0x0F3
    wd0 = wd_cnt; fe0 = fe_cnt;
    send_bits(3'd7, 16'h70F3, 0, 14, 1'b0);
    end_frame();
    repeat (3) @(negedge clk);
    check("long_wd_count", wd_cnt - wd0, 1);
    check("long_fe_count", fe_cnt - fe0, 0);
    read_sel(3'd7);
    check("long_hex", hex_a, 12'h0F3);
    check("long_dv", dv_a, 1'b1);
    check("long_chv", chv_a, 8'hA8);

    // reset mid-frame; frame resumes with data_ctrl already high at release
    send_bits(3'd0, 16'h0FFF, 0, 5, 1'b0);
    @(negedge clk);
    rst = 1'b1; dc = 1'b1; q0 = 3'd0; sin = 1'b1;
    #1;
    check("arst_busy", busy_a, 1'b0);
    check("arst_chv", chv_a, 8'h00);
    check("arst_hex", hex_a, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    send_bits(3'd0, 16'h0001, 1, 11, 1'b0);
    end_frame();
    repeat (2) @(negedge clk);
    read_sel(3'd0);
    check("rmid_hex_lsb", hex_a, 12'h001);
    check("rmid_dv", dv_a, 1'b1);
    check("rmid_hex_msbdut", hex_b, 12'h800);
    check("rmid_chv", chv_a, 8'h01);
    read_sel(3'd3);
    check("rmid_bank_clr", hex_a, 12'h000);
    check("rmid_dv_clr", dv_a, 1'b0);

    // same word sent MSB-first
    send_bits(3'd0, 16'h0001, 0, 11, 1'b1);
    end_frame();
    repeat (2) @(negedge clk);
    read_sel(3'd0);
    check("msb_hex", hex_b, 12'h001);
    check("msb_dv", dv_b, 1'b1);
    check("msb_hex_lsbdut", hex_a, 12'h800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
